sram_arbiter_2x1: RTL

- Shares one sram-like master port (the port that feeds cpu_axi_interface) between two sram-like requesters: instruction-cache refill (port I) and data path (port D).
- Arbitrates address-phase requests and tracks in-flight transactions in an owner FIFO, so each in-order data_ok returns to the requester that issued it.
- Sits between the cache/bridge_2x1 outputs and a single-master AXI interface.

---
 rtl/arb_pkg.sv | 12 +
 rtl/owner_fifo.sv | 57 +++++
 rtl/sram_arbiter_2x1.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-requester sram-like arbiter.
package arb_pkg;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  // A one-entry FIFO still needs a one-bit pointer so the ports stay legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding the owner of each in-flight
// transaction, oldest at the head. The caller never pushes when full and
// never pops when empty.
module owner_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] mem_q;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  if (DEPTH == 1) begin : g_one
    assign head_o = mem_q[0];
    // Single slot: the pointer is meaningless, always write entry 0.
    always_ff @(posedge clk) begin
      if (push_i) mem_q[0] <= din_i;
    end
  end else begin : g_many
    assign head_o = mem_q[rd_ptr_q];
    // Storage is not reset; stale entries are never read once count is 0.
    always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally; simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter_2x1.sv
// Two sram-like requesters (I = icache refill, D = data path) sharing one
// sram-like master port. Zero added latency on address and data paths.
// Owners of accepted requests are queued so in-order responses go back to
// the right requester. Optional macro ARB_ROUND_ROBIN_EN replaces fixed
// D-over-I priority with alternation when both request.
module sram_arbiter_2x1
  import arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_wr,
  input  logic [1:0]    i_size,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata
);

  lock_state_t state_q, state_d;
  owner_t      lock_owner_q, lock_owner_d, pick, grant;
  logic        granted_req, full, empty, fire, pop, head_bit;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t rr_last_q;

  // Remember the last winner so contention alternates between I and D.
  always_ff @(posedge clk) begin
    if (rst)       rr_last_q <= OWN_I;
    else if (fire) rr_last_q <= grant;
  end

  // Contention goes to whoever did not win last; idle defaults to D.
  always_comb begin
    pick = OWN_D;
    if (i_req && d_req) pick = (rr_last_q == OWN_D) ? OWN_I : OWN_D;
    else if (i_req)     pick = OWN_I;
  end
`else
  // Fixed priority D over I; idle defaults to D.
  always_comb begin
    pick = OWN_D;
    if (i_req && !d_req) pick = OWN_I;
  end
`endif

  // A stalled request keeps its grant so the payload cannot switch under it.
  assign grant       = rst ? OWN_D : (state_q == LOCKED) ? lock_owner_q : pick;
  assign granted_req = (grant == OWN_D) ? d_req : i_req;

  // full uses registered count: a same-cycle pop never opens a slot, which
  // keeps data_ok -> addr_ok free of a combinational path.
  assign m_req = granted_req & ~full & ~rst;
  assign fire  = m_req & m_addr_ok;
  assign pop   = m_data_ok & ~empty & ~rst;

  assign m_wr    = (grant == OWN_D) ? d_wr    : i_wr;
  assign m_size  = (grant == OWN_D) ? d_size  : i_size;
  assign m_addr  = (grant == OWN_D) ? d_addr  : i_addr;
  assign m_wdata = (grant == OWN_D) ? d_wdata : i_wdata;

  assign i_addr_ok = fire & (grant == OWN_I);
  assign d_addr_ok = fire & (grant == OWN_D);
  // Head bit: 1 = D, 0 = I.
  assign i_data_ok = pop & ~head_bit;
  assign d_data_ok = pop &  head_bit;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  owner_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fire),
    .pop_i   (pop),
    .din_i   (grant),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head_bit)
  );

  // Lock state and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      lock_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Lock when the master stalls a presented request; release on acceptance.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    case (state_q)
      UNLOCKED: if (m_req && !m_addr_ok) begin
        state_d      = LOCKED;
        lock_owner_d = grant;
      end
      LOCKED:   if (fire) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // A response with nothing in flight is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (!rst && m_data_ok)
      assert (!empty) else $warning("sram_arbiter_2x1: m_data_ok with nothing in flight ignored");
  end

endmodule
